esc_frame_sequencer: RTL and testbench

- Sits between the flight controller and the four per-motor ESC PWM interfaces.
- Latches four motor speed requests, clamps them and slew-limits them.
- Enforces an arm/disarm sequence.
- Issues one shared, frame-periodic write strobe that the ESC interfaces sample together with their 11-bit speed inputs.

---
 rtl/esc_frame_sequencer_if.sv | 29 ++
 rtl/esc_frame_sequencer.sv | 145 ++++++++++++++
 tb/tb_esc_frame_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/esc_frame_sequencer_if.sv
// Bundle between the flight controller and the ESC frame sequencer:
// speed requests in, frame-aligned speeds plus the shared write strobe out.
interface esc_frame_sequencer_if;
  // Strobes carry no backpressure. new_spds is a one-cycle capture pulse that
  // is accepted on any edge. wrt is a one-cycle pulse, and the four speeds are
  // valid from the wrt-high cycle until the next wrt. arm is a level.
  logic        arm;
  logic        new_spds;
  logic [10:0] frnt_spd_in;
  logic [10:0] bck_spd_in;
  logic [10:0] lft_spd_in;
  logic [10:0] rght_spd_in;
  logic [10:0] frnt_spd;
  logic [10:0] bck_spd;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        wrt;
  logic        armed;

  modport master (
    output arm, new_spds, frnt_spd_in, bck_spd_in, lft_spd_in, rght_spd_in,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, wrt, armed
  );

  modport slave (
    input  arm, new_spds, frnt_spd_in, bck_spd_in, lft_spd_in, rght_spd_in,
    output frnt_spd, bck_spd, lft_spd, rght_spd, wrt, armed
  );
endinterface

// File: rtl/esc_frame_sequencer.sv
// Frame-periodic ESC speed sequencer: captures targets, clamps and slew-limits
// them, and gates them behind a DISARMED -> ARMING -> RUN sequence.
module esc_frame_sequencer #(
  parameter int          FRAME_CYCLES = 125000,
  parameter int          ARM_FRAMES   = 256,
  parameter int          SLEW_STEP    = 64,
  parameter logic [10:0] MIN_SPEED    = 11'd0,
  parameter logic [10:0] MAX_SPEED    = 11'd2047
) (
  input  logic                        clk,
  input  logic                        rst,
  esc_frame_sequencer_if.slave        bus,
  output logic [1:0]                  state_dbg
);

  localparam int             CW       = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0]  TC_VAL   = CW'(FRAME_CYCLES - 1);
  localparam logic [9:0]     ARM_LAST = 10'(ARM_FRAMES - 1);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] frame_cnt;
  logic          tc;
  logic [9:0]    arm_cnt, arm_cnt_nxt;
  logic [10:0]   tgt_frnt, tgt_bck, tgt_lft, tgt_rght;
  logic [10:0]   frnt_nxt, bck_nxt, lft_nxt, rght_nxt;

  assign tc        = (frame_cnt == TC_VAL);
  assign state_dbg = state;

  // Differences are taken in full-width signed arithmetic so a large step
  // near either end of the range can never wrap.
  function automatic logic [10:0] slew(input logic [10:0] cur,
                                       input logic [10:0] tgt);
    int t;
    int c;
    int d;
    t = int'(tgt);
    c = int'(cur);
    if (t < int'(MIN_SPEED)) t = int'(MIN_SPEED);
    if (t > int'(MAX_SPEED)) t = int'(MAX_SPEED);
    d = t - c;
    if (d > SLEW_STEP)       slew = 11'(c + SLEW_STEP);
    else if (d < -SLEW_STEP) slew = 11'(c - SLEW_STEP);
    else                     slew = 11'(t);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= DISARMED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    arm_cnt_nxt = arm_cnt;
    frnt_nxt    = bus.frnt_spd;
    bck_nxt     = bus.bck_spd;
    lft_nxt     = bus.lft_spd;
    rght_nxt    = bus.rght_spd;
    case (state)
      DISARMED: begin
        frnt_nxt = '0;
        bck_nxt  = '0;
        lft_nxt  = '0;
        rght_nxt = '0;
        if (bus.arm) begin
          state_nxt   = ARMING;
          arm_cnt_nxt = '0;
        end
      end
      ARMING: begin
        frnt_nxt = '0;
        bck_nxt  = '0;
        lft_nxt  = '0;
        rght_nxt = '0;
        if (tc) begin
          arm_cnt_nxt = arm_cnt + 10'd1;
          if (arm_cnt == ARM_LAST) state_nxt = RUN;
        end
      end
      RUN: begin
        if (tc) begin
          frnt_nxt = slew(bus.frnt_spd, tgt_frnt);
          bck_nxt  = slew(bus.bck_spd,  tgt_bck);
          lft_nxt  = slew(bus.lft_spd,  tgt_lft);
          rght_nxt = slew(bus.rght_spd, tgt_rght);
        end
      end
      default: begin
        state_nxt = DISARMED;
        frnt_nxt  = '0;
        bck_nxt   = '0;
        lft_nxt   = '0;
        rght_nxt  = '0;
      end
    endcase
    // Disarm wins over everything and takes effect immediately, not at TC.
    if (!bus.arm) begin
      state_nxt = DISARMED;
      frnt_nxt  = '0;
      bck_nxt   = '0;
      lft_nxt   = '0;
      rght_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt    <= '0;
      arm_cnt      <= '0;
      bus.wrt      <= 1'b0;
      bus.armed    <= 1'b0;
      bus.frnt_spd <= '0;
      bus.bck_spd  <= '0;
      bus.lft_spd  <= '0;
      bus.rght_spd <= '0;
      tgt_frnt     <= '0;
      tgt_bck      <= '0;
      tgt_lft      <= '0;
      tgt_rght     <= '0;
    end else begin
      frame_cnt    <= tc ? '0 : frame_cnt + CW'(1);
      arm_cnt      <= arm_cnt_nxt;
      bus.wrt      <= tc;
      bus.armed    <= (state_nxt == RUN);
      bus.frnt_spd <= frnt_nxt;
      bus.bck_spd  <= bck_nxt;
      bus.lft_spd  <= lft_nxt;
      bus.rght_spd <= rght_nxt;
      // A capture on the TC edge lands after this frame's slew used the old targets.
      if (bus.new_spds) begin
        tgt_frnt <= bus.frnt_spd_in;
        tgt_bck  <= bus.bck_spd_in;
        tgt_lft  <= bus.lft_spd_in;
        tgt_rght <= bus.rght_spd_in;
      end
    end
  end

endmodule

// File: tb/tb_esc_frame_sequencer.sv
// Directed bench for esc_frame_sequencer: stimulus queues expected frames and
// cycle snapshots; a negedge monitor pops and compares them.
module tb_esc_frame_sequencer;

  localparam int W_WRT  = 77;  // cyc, armed, 4 speeds
  localparam int W_SNAP = 80;  // cyc, state, armed, wrt, 4 speeds
  localparam logic [1:0] S_DIS = 2'd0;
  localparam logic [1:0] S_ARM = 2'd1;
  localparam logic [1:0] S_RUN = 2'd2;

  logic        clk;
  logic        rst;
  logic [1:0]  state_dbg;
  logic [31:0] cyc;
  logic        done;
  int          n_cmp;
  int          n_err;

  logic [W_WRT-1:0]  exp_q[$];
  logic [W_SNAP-1:0] snap_q[$];
  logic [W_WRT-1:0]  e_w, g_w;
  logic [W_SNAP-1:0] e_s, g_s;

  esc_frame_sequencer_if bus ();

  esc_frame_sequencer #(
    .FRAME_CYCLES(100),
    .ARM_FRAMES  (4),
    .SLEW_STEP   (64),
    .MIN_SPEED   (11'd0),
    .MAX_SPEED   (11'd2047)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // Clock / reset-relative cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 32'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic goto(input int c);
    int n;
    n = 0;
    while (cyc != 32'(c) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) begin
      $display("FAIL goto: cycle %0d never reached, now %0d", c, cyc);
      $fatal(1, "goto bound");
    end
  endtask

  task automatic pulse_spds(input int f, input int b, input int l, input int r);
    bus.frnt_spd_in = 11'(f);
    bus.bck_spd_in  = 11'(b);
    bus.lft_spd_in  = 11'(l);
    bus.rght_spd_in = 11'(r);
    bus.new_spds    = 1'b1;
    @(negedge clk);
    bus.new_spds    = 1'b0;
  endtask

  task automatic push_wrt(input int c, input logic a,
                          input int f, input int b, input int l, input int r);
    exp_q.push_back({32'(c), a, 11'(f), 11'(b), 11'(l), 11'(r)});
  endtask

  task automatic push_snap(input int c, input logic [1:0] s, input logic a,
                           input int f, input int b, input int l, input int r);
    snap_q.push_back({32'(c), s, a, 1'b0, 11'(f), 11'(b), 11'(l), 11'(r)});
  endtask

  function automatic int cap(input int x);
    return (x > 1000) ? 1000 : x;
  endfunction

  // Stimulus
  initial begin
    rst              = 1'b1;
    done             = 1'b0;
    bus.arm          = 1'b0;
    bus.new_spds     = 1'b0;
    bus.frnt_spd_in  = '0;
    bus.bck_spd_in   = '0;
    bus.lft_spd_in   = '0;
    bus.rght_spd_in  = '0;
    push_snap(1, S_DIS, 1'b0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Disarmed cadence
    push_wrt(100, 1'b0, 0, 0, 0, 0);
    push_wrt(200, 1'b0, 0, 0, 0, 0);
    push_wrt(300, 1'b0, 0, 0, 0, 0);

    // Arm sequence then ramp to 300
    goto(310);
    push_snap(312, S_ARM, 1'b0, 0, 0, 0, 0);
    push_snap(701, S_RUN, 1'b1, 0, 0, 0, 0);
    push_wrt(400, 1'b0, 0, 0, 0, 0);
    push_wrt(500, 1'b0, 0, 0, 0, 0);
    push_wrt(600, 1'b0, 0, 0, 0, 0);
    push_wrt(700, 1'b1, 0, 0, 0, 0);
    push_wrt(800, 1'b1, 64, 64, 64, 64);
    push_wrt(900, 1'b1, 128, 128, 128, 128);
    push_wrt(1000, 1'b1, 192, 192, 192, 192);
    push_wrt(1100, 1'b1, 256, 256, 256, 256);
    push_wrt(1200, 1'b1, 300, 300, 300, 300);
    push_wrt(1300, 1'b1, 300, 300, 300, 300);
    bus.arm = 1'b1;
    pulse_spds(300, 300, 300, 300);

    // Mixed steps: large up, large down, small up, small down
    goto(1310);
    push_wrt(1400, 1'b1, 364, 236, 310, 250);
    pulse_spds(2047, 0, 310, 250);

    goto(1410);
    push_wrt(1500, 1'b1, 300, 300, 300, 300);
    pulse_spds(300, 300, 300, 300);

    // Capture coinciding with TC applies one frame late
    goto(1599);
    push_wrt(1600, 1'b1, 300, 300, 300, 300);
    push_wrt(1700, 1'b1, 364, 300, 300, 300);
    pulse_spds(1000, 300, 300, 300);

    goto(1710);
    for (int k = 1; k <= 11; k++)
      push_wrt(1700 + 100 * k, 1'b1, cap(364 + 64 * k), cap(300 + 64 * k),
               cap(300 + 64 * k), cap(300 + 64 * k));
    pulse_spds(1000, 1000, 1000, 1000);

    // Mid-frame disarm
    goto(2830);
    push_snap(2837, S_RUN, 1'b1, 1000, 1000, 1000, 1000);
    push_snap(2838, S_DIS, 1'b0, 0, 0, 0, 0);
    push_wrt(2900, 1'b0, 0, 0, 0, 0);
    goto(2837);
    bus.arm = 1'b0;

    // Re-arm, then reset on the TC edge
    goto(2910);
    push_wrt(3000, 1'b0, 0, 0, 0, 0);
    push_wrt(3100, 1'b0, 0, 0, 0, 0);
    push_wrt(3200, 1'b0, 0, 0, 0, 0);
    push_wrt(3300, 1'b1, 0, 0, 0, 0);
    push_wrt(3400, 1'b1, 64, 64, 64, 64);
    push_wrt(3500, 1'b1, 128, 128, 128, 128);
    bus.arm = 1'b1;
    pulse_spds(500, 500, 500, 500);

    goto(3599);
    push_snap(0, S_DIS, 1'b0, 0, 0, 0, 0);
    push_snap(1, S_ARM, 1'b0, 0, 0, 0, 0);
    push_wrt(100, 1'b0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    goto(150);
    done = 1'b1;
    repeat (5) @(negedge clk);
  end

  // Scoreboard monitor
  initial begin
    n_cmp = 0;
    n_err = 0;
    forever begin
      @(negedge clk);
      if (bus.wrt === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wrt_unexpected: wrt high at cycle %0d, none required", cyc);
        end else begin
          e_w = exp_q.pop_front();
          g_w = {cyc, bus.armed, bus.frnt_spd, bus.bck_spd, bus.lft_spd, bus.rght_spd};
          if (g_w !== e_w) begin
            n_err++;
            $display("FAIL wrt_frame: got cyc=%0d armed=%0d spd=%0d/%0d/%0d/%0d, required cyc=%0d armed=%0d spd=%0d/%0d/%0d/%0d",
                     g_w[76:45], g_w[44], g_w[43:33], g_w[32:22], g_w[21:11], g_w[10:0],
                     e_w[76:45], e_w[44], e_w[43:33], e_w[32:22], e_w[21:11], e_w[10:0]);
          end
        end
      end
      if (snap_q.size() != 0 && snap_q[0][79:48] == cyc) begin
        e_s = snap_q.pop_front();
        g_s = {cyc, state_dbg, bus.armed, bus.wrt, bus.frnt_spd, bus.bck_spd,
               bus.lft_spd, bus.rght_spd};
        n_cmp++;
        if (g_s !== e_s) begin
          n_err++;
          $display("FAIL snapshot@%0d: got state=%0d armed=%0d wrt=%0d spd=%0d/%0d/%0d/%0d, required state=%0d armed=%0d wrt=%0d spd=%0d/%0d/%0d/%0d",
                   cyc, g_s[47:46], g_s[45], g_s[44], g_s[43:33], g_s[32:22], g_s[21:11], g_s[10:0],
                   e_s[47:46], e_s[45], e_s[44], e_s[43:33], e_s[32:22], e_s[21:11], e_s[10:0]);
        end
      end
      if (done) begin
        n_cmp++;
        if (exp_q.size() != 0 || snap_q.size() != 0) begin
          n_err++;
          $display("FAIL queues_drained: got %0d frames and %0d snapshots left, required 0 and 0",
                   exp_q.size(), snap_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    end
  end

endmodule
